// File: rtl/cgra_run_ctrl.sv
// Run controller for a CGRA kernel: sequences work items through the BRAM start/done handshake.
// Optional per-item watchdog is enabled by defining RUN_TIMEOUT_EN.
module cgra_run_ctrl #(
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Run_Start,
  input  logic [CNT_WIDTH-1:0] Run_Num_Items,
  input  logic                 Run_Abort,
  output logic                 Run_Busy,
  output logic                 Run_Done,
  output logic                 Run_Error,
  output logic [CNT_WIDTH-1:0] Run_Item_Cnt,
  output logic [31:0]          Run_Cycles,
  output logic                 Computation_Start,
  input  logic                 Computation_Done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] num_items;
  logic [CNT_WIDTH-1:0] item_cnt_inc;
  logic                 start_ok;
  logic                 abort_hit;
  logic                 timeout_hit;
  logic                 item_finish;
  logic                 last_item;
  logic                 cs_nxt;
  logic                 busy_nxt;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range_check
    $error("cgra_run_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  assign item_cnt_inc = Run_Item_Cnt + CNT_WIDTH'(1);
  assign start_ok     = (state == IDLE) && Run_Start;
  assign abort_hit    = (state != IDLE) && Run_Abort;
  assign item_finish  = (state == DRAIN) && !Computation_Done;
  assign last_item    = (item_cnt_inc == num_items);

`ifdef RUN_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wdog;

  assign timeout_hit = (state != IDLE) && (wdog == WD_LAST);

  // Per-item watchdog restarts on each entry into RUN and keeps counting through DRAIN.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wdog <= '0;
    end else if ((state_nxt == RUN) && (state != RUN)) begin
      wdog <= '0;
    end else if (state != IDLE) begin
      wdog <= wdog + WD_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort outranks the watchdog, which outranks the normal handshake transitions.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (Run_Start && (Run_Num_Items != '0)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (Run_Abort || timeout_hit) begin
          state_nxt = IDLE;
        end else if (Computation_Done) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (Run_Abort || timeout_hit) begin
          state_nxt = IDLE;
        end else if (!Computation_Done) begin
          state_nxt = last_item ? IDLE : RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cs_nxt   = (state_nxt == RUN);
    busy_nxt = (state_nxt != IDLE);
  end

  // Registered outputs and run bookkeeping; a zero-item start completes immediately.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Computation_Start <= 1'b0;
      Run_Busy          <= 1'b0;
      Run_Done          <= 1'b0;
      Run_Error         <= 1'b0;
      Run_Item_Cnt      <= '0;
      Run_Cycles        <= '0;
      num_items         <= '0;
    end else begin
      Computation_Start <= cs_nxt;
      Run_Busy          <= busy_nxt;
      if (start_ok) begin
        num_items    <= Run_Num_Items;
        Run_Item_Cnt <= '0;
        Run_Cycles   <= '0;
        Run_Done     <= (Run_Num_Items == '0);
        Run_Error    <= 1'b0;
      end else begin
        if ((state != IDLE) && (Run_Cycles != 32'hFFFF_FFFF)) begin
          Run_Cycles <= Run_Cycles + 32'd1;
        end
        if (abort_hit || timeout_hit) begin
          Run_Done  <= 1'b1;
          Run_Error <= 1'b1;
        end else if (item_finish) begin
          Run_Item_Cnt <= item_cnt_inc;
          if (last_item) begin
            Run_Done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cgra_run_ctrl.sv
// Bench for cgra_run_ctrl: table vectors, randomized runs against an arithmetic run model,
// and hand sequences for reset, idle-state inputs and the watchdog.
module tb_cgra_run_ctrl;

  localparam int CW = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Run_Start;
  logic [CW-1:0] Run_Num_Items;
  logic          Run_Abort;
  logic          Run_Busy;
  logic          Run_Done;
  logic          Run_Error;
  logic [CW-1:0] Run_Item_Cnt;
  logic [31:0]   Run_Cycles;
  logic          Computation_Start;
  logic          Computation_Done;

  logic bram_done;
  logic force_en;
  logic force_val;
  int   d_up;
  int   d_dn;
  int   vec_count;
  int   miss_count;

  typedef struct {
    int n;
    int up;
    int dn;
    int abort_item;
    int abort_dly;
    int ign_at;
    bit start_abort;
    int exp_cnt;
    int exp_err;
    int exp_pulses;
    int exp_cycles;
  } vec_t;

  vec_t tbl[7];

  assign Computation_Done = force_en ? force_val : bram_done;

  always #5 Clk = ~Clk;

  cgra_run_ctrl #(
    .CNT_WIDTH      (CW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .Clk               (Clk),
    .Rst               (Rst),
    .Run_Start         (Run_Start),
    .Run_Num_Items     (Run_Num_Items),
    .Run_Abort         (Run_Abort),
    .Run_Busy          (Run_Busy),
    .Run_Done          (Run_Done),
    .Run_Error         (Run_Error),
    .Run_Item_Cnt      (Run_Item_Cnt),
    .Run_Cycles        (Run_Cycles),
    .Computation_Start (Computation_Start),
    .Computation_Done  (Computation_Done)
  );

  // BRAM side: done rises d_up cycles after start rises, falls d_dn cycles after start falls.
  initial begin : bram_model
    int up_cnt;
    int dn_cnt;
    bram_done = 1'b0;
    up_cnt    = 0;
    dn_cnt    = 0;
    forever begin
      @(negedge Clk);
      if (Computation_Start) begin
        dn_cnt = 0;
        up_cnt++;
        if (up_cnt == d_up) bram_done = 1'b1;
      end else begin
        up_cnt = 0;
        if (bram_done) begin
          dn_cnt++;
          if (dn_cnt >= d_dn) begin
            bram_done = 1'b0;
            dn_cnt    = 0;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    vec_count++;
    if (actual != expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Each item costs d_up cycles in RUN plus d_dn cycles in DRAIN; an abort cuts the run short.
  function automatic vec_t modelRun(input int n, input int up, input int dn,
                                    input int abort_item, input int abort_dly);
    vec_t v;
    v.n = n; v.up = up; v.dn = dn;
    v.abort_item = abort_item; v.abort_dly = abort_dly;
    v.ign_at = 0; v.start_abort = 1'b0;
    if (abort_item != 0) begin
      v.exp_cnt    = abort_item - 1;
      v.exp_err    = 1;
      v.exp_pulses = abort_item;
      v.exp_cycles = (abort_item - 1) * (up + dn) + abort_dly + 1;
    end else begin
      v.exp_cnt    = n;
      v.exp_err    = 0;
      v.exp_pulses = n;
      v.exp_cycles = n * (up + dn);
    end
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    int  pulses;
    int  cyc;
    int  rise_cyc;
    bit  cs_prev;
    bit  aborted;
    d_up = v.up;
    d_dn = v.dn;
    @(negedge Clk);
    Run_Num_Items = CW'(v.n);
    Run_Start     = 1'b1;
    Run_Abort     = v.start_abort;
    @(negedge Clk);
    Run_Start = 1'b0;
    Run_Abort = 1'b0;
    pulses = 0; cyc = 0; rise_cyc = 0; cs_prev = 1'b0; aborted = 1'b0;
    if (v.start_abort) begin
      checkOutput("start_abort_busy", Run_Busy, 1);
      checkOutput("start_abort_err", Run_Error, 0);
      checkOutput("start_abort_done", Run_Done, 0);
    end
    if (v.n == 0) begin
      checkOutput("zero_busy", Run_Busy, 0);
    end else begin
      while (Run_Busy && cyc < 2000) begin
        if (Computation_Start && !cs_prev) begin
          pulses++;
          rise_cyc = cyc;
        end
        cs_prev   = Computation_Start;
        Run_Abort = (v.abort_item != 0) && !aborted && (pulses == v.abort_item) &&
                    Computation_Start && ((cyc - rise_cyc) == v.abort_dly);
        if (Run_Abort) aborted = 1'b1;
        Run_Start = (v.ign_at != 0) && (cyc == v.ign_at);
        if (Run_Start) Run_Num_Items = CW'(9);
        @(negedge Clk);
        cyc++;
      end
      Run_Abort = 1'b0;
      Run_Start = 1'b0;
      checkOutput("run_budget", (cyc < 2000) ? 1 : 0, 1);
    end
    checkOutput("end_item_cnt", Run_Item_Cnt, v.exp_cnt);
    checkOutput("end_done", Run_Done, 1);
    checkOutput("end_error", Run_Error, v.exp_err);
    checkOutput("end_comp_start", Computation_Start, 0);
    checkOutput("end_cycles", Run_Cycles, v.exp_cycles);
    cs_prev = Computation_Start;
    for (int i = 0; i < 3 + v.dn; i++) begin
      @(negedge Clk);
      if (Computation_Start && !cs_prev) pulses++;
      cs_prev = Computation_Start;
    end
    checkOutput("pulse_count", pulses, v.exp_pulses);
    checkOutput("idle_busy", Run_Busy, 0);
    checkOutput("held_done", Run_Done, 1);
    checkOutput("held_error", Run_Error, v.exp_err);
  endtask

  initial begin : main
    vec_t v;
    int   cyc;
    int   n, up, dn, ai, ad;
    vec_count = 0; miss_count = 0;
    Rst = 1'b1; Run_Start = 1'b0; Run_Abort = 1'b0; Run_Num_Items = '0;
    force_en = 1'b0; force_val = 1'b0; d_up = 1; d_dn = 1;

    repeat (2) @(negedge Clk);
    checkOutput("reset_busy", Run_Busy, 0);
    checkOutput("reset_done", Run_Done, 0);
    checkOutput("reset_error", Run_Error, 0);
    checkOutput("reset_cnt", Run_Item_Cnt, 0);
    checkOutput("reset_cycles", Run_Cycles, 0);
    checkOutput("reset_comp_start", Computation_Start, 0);
    Rst = 1'b0;

    //               n up dn ab dly ign sa  cnt err pul cyc
    tbl[0] = '{3, 5, 2, 0, 0, 0, 1'b0, 3, 0, 3, 21};
    tbl[1] = '{0, 1, 1, 0, 0, 0, 1'b0, 0, 0, 0, 0};
    tbl[2] = '{4, 4, 3, 2, 1, 0, 1'b0, 1, 1, 2, 9};
    tbl[3] = '{2, 3, 2, 0, 0, 4, 1'b0, 2, 0, 2, 10};
    tbl[4] = '{2, 2, 1, 0, 0, 0, 1'b1, 2, 0, 2, 6};
    tbl[5] = '{1, 1, 1, 0, 0, 0, 1'b0, 1, 0, 1, 2};
    tbl[6] = '{5, 3, 3, 1, 0, 0, 1'b0, 0, 1, 1, 1};
    for (int i = 0; i < 7; i++) applyStimulus(tbl[i]);

    // Abort and done while idle must leave the sticky flags of the aborted run alone.
    @(negedge Clk);
    Run_Abort = 1'b1;
    @(negedge Clk);
    Run_Abort = 1'b0;
    force_en  = 1'b1;
    force_val = 1'b1;
    repeat (3) @(negedge Clk);
    checkOutput("idle_abort_done", Run_Done, 1);
    checkOutput("idle_abort_error", Run_Error, 1);
    checkOutput("idle_cdone_busy", Run_Busy, 0);
    checkOutput("idle_cdone_cs", Computation_Start, 0);
    force_en = 1'b0;

    for (int i = 0; i < 20; i++) begin
      n  = $urandom_range(1, 6);
      up = $urandom_range(1, 6);
      dn = $urandom_range(1, 4);
      ai = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n) : 0;
      ad = $urandom_range(0, up - 1);
      v  = modelRun(n, up, dn, ai, ad);
      applyStimulus(v);
    end

    // Reset while the first item drains.
    d_up = 3; d_dn = 4;
    @(negedge Clk);
    Run_Num_Items = CW'(3);
    Run_Start     = 1'b1;
    @(negedge Clk);
    Run_Start = 1'b0;
    cyc = 0;
    while (!(Run_Busy && !Computation_Start) && cyc < 100) begin
      @(negedge Clk);
      cyc++;
    end
    checkOutput("drain_reached", (cyc < 100) ? 1 : 0, 1);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    checkOutput("mid_rst_busy", Run_Busy, 0);
    checkOutput("mid_rst_done", Run_Done, 0);
    checkOutput("mid_rst_error", Run_Error, 0);
    checkOutput("mid_rst_cnt", Run_Item_Cnt, 0);
    checkOutput("mid_rst_cycles", Run_Cycles, 0);
    checkOutput("mid_rst_cs", Computation_Start, 0);
    repeat (6) @(negedge Clk);
    applyStimulus(modelRun(1, 2, 2, 0, 0));

    // Done held low forever: only the watchdog (if built) can end the run.
    force_en  = 1'b1;
    force_val = 1'b0;
    @(negedge Clk);
    Run_Num_Items = CW'(1);
    Run_Start     = 1'b1;
    @(negedge Clk);
    Run_Start = 1'b0;
    cyc = 0;
    while (Run_Busy && cyc < 1000) begin
      @(negedge Clk);
      cyc++;
    end
`ifdef RUN_TIMEOUT_EN
    checkOutput("timeout_cycles_in_run", cyc, 16);
    checkOutput("timeout_error", Run_Error, 1);
    checkOutput("timeout_done", Run_Done, 1);
    checkOutput("timeout_cs", Computation_Start, 0);
    checkOutput("timeout_run_cycles", Run_Cycles, 16);
`else
    checkOutput("no_timeout_busy", Run_Busy, 1);
    checkOutput("no_timeout_cs", Computation_Start, 1);
    checkOutput("no_timeout_error", Run_Error, 0);
    Run_Abort = 1'b1;
    @(negedge Clk);
    Run_Abort = 1'b0;
    checkOutput("cleanup_abort_busy", Run_Busy, 0);
    checkOutput("cleanup_abort_error", Run_Error, 1);
`endif
    force_en = 1'b0;
    repeat (2) @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/cgra_run_ctrl.md
CGRA_RUN_CTRL -- requirements
Module: cgra_run_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, setting the width of the work-item count.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048576, setting the per-work-item watchdog limit in Clk cycles.
REQ-003 Clk  input  1  single clock; all logic on its rising edge.
REQ-004 Rst  input  1  synchronous, active-high reset.
REQ-005 Run_Start  input  1  host one-cycle pulse requesting a kernel run.
REQ-006 Run_Num_Items  input  CNT_WIDTH  number of work items, sampled on an accepted Run_Start.
REQ-007 Run_Abort  input  1  host pulse that cancels the current run.
REQ-008 Run_Busy  output  1  high while a run is in progress.
REQ-009 Run_Done  output  1  sticky run-completion flag.
REQ-010 Run_Error  output  1  sticky flag; high when a run ended by abort or timeout.
REQ-011 Run_Item_Cnt  output  CNT_WIDTH  number of work items completed in the current or last run.
REQ-012 Run_Cycles  output  32  Clk cycles spent in RUN and DRAIN, saturating.
REQ-013 Computation_Start  output  1  level to the BRAM interface; held high for the duration of one work item.
REQ-014 Computation_Done  input  1  level from the BRAM interface; high from work-item end until Computation_Start falls and the interface clears it.

Function
REQ-015 SHALL implement the states IDLE, RUN and DRAIN, all registered.
REQ-016 IDLE, Run_Start=1, Run_Num_Items!=0: next cycle SHALL enter RUN with these effects.
- Run_Num_Items latched; Run_Item_Cnt, Run_Cycles, Run_Done and Run_Error cleared.
- Run_Busy set to 1.
REQ-017 IDLE, Run_Start=1, Run_Num_Items=0: SHALL stay in IDLE with Run_Done=1 and Run_Error=0 next cycle.
REQ-018 Run_Start outside IDLE SHALL be ignored.
REQ-019 Computation_Start SHALL be a registered output, equal to 1 exactly in the cycles where the state is RUN.
REQ-020 RUN, Computation_Done=1: SHALL enter DRAIN next cycle.
REQ-021 DRAIN, Computation_Done=0: SHALL increment Run_Item_Cnt (CNT_WIDTH bits, no wrap possible), then branch on the result.
- Incremented count equals the latched item count: enter IDLE with Run_Done=1 and Run_Busy=0.
- Otherwise: re-enter RUN.
REQ-022 Run_Cycles SHALL increment once per cycle in RUN or DRAIN and saturate at 32'hFFFFFFFF.
REQ-023 Run_Abort=1 in RUN or DRAIN SHALL force IDLE next cycle with these effects, taking priority over every other transition in that cycle.
- Computation_Start=0, Run_Busy=0, Run_Done=1, Run_Error=1.
- Run_Item_Cnt frozen.
REQ-024 Run_Abort in IDLE SHALL have no effect.
REQ-025 Run_Start and Run_Abort asserted together in IDLE SHALL start a run (Run_Abort ignored).
REQ-026 Computation_Done=1 while in IDLE SHALL be ignored.
REQ-027 Run_Done and Run_Error SHALL hold their values until the next accepted Run_Start or reset.

Reset
REQ-028 Rst=1 SHALL force the following on the next edge, regardless of state, including mid-run:
- state IDLE;
- Computation_Start=0, Run_Busy=0, Run_Done=0, Run_Error=0;
- Run_Item_Cnt=0, Run_Cycles=0;
- watchdog counter=0.

Configuration
REQ-029 Macro RUN_TIMEOUT_EN defined: the watchdog SHALL operate as follows.
- A per-item counter clears on every entry into RUN and counts cycles in RUN and DRAIN.
- Reaching TIMEOUT_CYCLES-1 SHALL force IDLE next cycle with Computation_Start=0, Run_Busy=0, Run_Done=1, Run_Error=1.
- Run_Abort takes priority over the timeout.
REQ-030 Macro RUN_TIMEOUT_EN undefined: no watchdog logic SHALL exist; Run_Error is set only by Run_Abort; TIMEOUT_CYCLES is unused.

Verification
REQ-031 Normal run: Run_Num_Items=3, Computation_Done rises 5 cycles after each Computation_Start rise and falls 2 cycles after each Computation_Start fall.
- Required: 3 Computation_Start high pulses.
- Required: Run_Item_Cnt=3, Run_Done=1, Run_Error=0, Run_Busy=0.
REQ-032 Zero items: Run_Num_Items=0 with Run_Start.
- Required: Computation_Start never rises; Run_Done=1 and Run_Item_Cnt=0 one cycle later.
REQ-033 Abort mid-run: Run_Num_Items=4, Run_Abort during the second item's RUN.
- Required next cycle: Computation_Start=0, Run_Done=1, Run_Error=1, Run_Item_Cnt=1.
REQ-034 Ignored start: Run_Start pulsed while Run_Busy=1 with Run_Num_Items=9 (run started with 2).
- Required: run completes with Run_Item_Cnt=2; no restart.
REQ-035 Timeout (RUN_TIMEOUT_EN, TIMEOUT_CYCLES=16): Computation_Done held 0.
- Required: IDLE after 16 cycles in RUN; Run_Error=1, Run_Done=1, Computation_Start=0.
- Without the macro: still in RUN after 1000 cycles.
REQ-036 Reset mid-DRAIN: Rst=1 for one cycle.
- Required next cycle: all outputs zero, state IDLE.
- A subsequent Run_Start with Run_Num_Items=1 completes normally.
